// File: rtl/mem_arbiter_if.sv
// Core-side and memory-side bus bundle of the shared data-memory arbiter.
interface mem_arbiter_if #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 12
);
    logic [NUM_CORES-1:0]            req;
    logic [NUM_CORES-1:0]            we;
    logic [NUM_CORES*ADDR_WIDTH-1:0] addr;
    logic [NUM_CORES*DATA_WIDTH-1:0] wdata;
    logic [NUM_CORES-1:0]            lock;
    logic [NUM_CORES-1:0]            gnt;
    logic [NUM_CORES-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]           rdata;
    logic                            mem_en;
    logic                            mem_we;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic [DATA_WIDTH-1:0]           mem_rdata;

    modport slave (
        input  req, we, addr, wdata, lock, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, lock, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data-memory port among NUM_CORES cores.
// Define ARB_LOCK_EN to let a granted core hold the bus for up to MAX_LOCK accesses.
module mem_arbiter #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned MAX_LOCK   = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_CORES);
    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2} state_t;

    state_t                 r_state, w_state_n;
    logic [IDX_W-1:0]       r_rr_ptr, w_rr_ptr_n;
    logic [IDX_W-1:0]       r_winner, w_winner_n;
    logic [IDX_W-1:0]       w_win, w_idx, w_win_next;
    logic                   w_found;
    logic [NUM_CORES-1:0]   w_cand;
    logic [LAT_W-1:0]       r_lat, w_lat_n;
    logic [NUM_CORES-1:0]   r_gnt, w_gnt_n, r_rvalid, w_rvalid_n;
    logic [DATA_WIDTH-1:0]  r_rdata, w_rdata_n, r_mem_wdata, w_mem_wdata_n;
    logic                   r_mem_en, w_mem_en_n, r_mem_we, w_mem_we_n;
    logic [ADDR_WIDTH-1:0]  r_mem_addr, w_mem_addr_n;

`ifdef ARB_LOCK_EN
    localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);
    logic              r_locked, w_locked_n, w_locked;
    logic [LOCK_W-1:0] r_lock_cnt, w_lock_cnt_n;

    // Locked: only the last winner may be granted, re-armed on its write or its rvalid cycle.
    assign w_locked = (r_state == IDLE) && bus.lock[r_winner] &&
                      (r_locked || ((|r_rvalid) && (r_lock_cnt < LOCK_W'(MAX_LOCK))));
    assign w_cand   = w_locked ? (bus.req & (NUM_CORES'(1) << r_winner)) : bus.req;
`else
    logic w_unused_lock;
    assign w_unused_lock = ^{bus.lock, 32'(MAX_LOCK)};
    assign w_cand        = bus.req;
`endif

    // First requesting core at or after rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            w_idx = IDX_W'((32'(r_rr_ptr) + k) % NUM_CORES);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_win_next = (32'(w_win) == NUM_CORES - 1) ? '0 : w_win + 1'b1;

    always_comb begin
        w_state_n     = r_state;
        w_rr_ptr_n    = r_rr_ptr;
        w_winner_n    = r_winner;
        w_lat_n       = r_lat;
        w_gnt_n       = '0;
        w_rvalid_n    = '0;
        w_rdata_n     = r_rdata;
        w_mem_en_n    = 1'b0;
        w_mem_we_n    = 1'b0;
        w_mem_addr_n  = r_mem_addr;
        w_mem_wdata_n = r_mem_wdata;
`ifdef ARB_LOCK_EN
        w_locked_n    = r_locked;
        w_lock_cnt_n  = r_lock_cnt;
`endif
        case (r_state)
            IDLE: begin
`ifdef ARB_LOCK_EN
                w_locked_n = w_locked;
`endif
                if (w_found) begin
                    w_winner_n    = w_win;
                    w_gnt_n       = NUM_CORES'(1) << w_win;
                    w_mem_en_n    = 1'b1;
                    w_mem_we_n    = bus.we[w_win];
                    w_mem_addr_n  = bus.addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
                    w_mem_wdata_n = bus.wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
                    w_rr_ptr_n    = w_win_next;
                    w_state_n     = ACCESS;
`ifdef ARB_LOCK_EN
                    w_lock_cnt_n  = w_locked ? r_lock_cnt + 1'b1 : LOCK_W'(1);
`endif
                end
            end
            ACCESS: begin
                if (r_mem_we) begin
                    w_state_n  = IDLE;
`ifdef ARB_LOCK_EN
                    w_locked_n = bus.lock[r_winner] && (r_lock_cnt < LOCK_W'(MAX_LOCK));
`endif
                end else begin
                    w_lat_n    = LAT_W'(MEM_LAT - 1);
                    w_state_n  = WAIT;
`ifdef ARB_LOCK_EN
                    w_locked_n = 1'b0;
`endif
                end
            end
            WAIT: begin
                if (r_lat == '0) begin
                    w_rdata_n  = bus.mem_rdata;
                    w_rvalid_n = NUM_CORES'(1) << r_winner;
                    w_state_n  = IDLE;
                end else begin
                    w_lat_n = r_lat - 1'b1;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_winner    <= '0;
            r_lat       <= '0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_rdata     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef ARB_LOCK_EN
            r_locked    <= 1'b0;
            r_lock_cnt  <= '0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_rr_ptr    <= w_rr_ptr_n;
            r_winner    <= w_winner_n;
            r_lat       <= w_lat_n;
            r_gnt       <= w_gnt_n;
            r_rvalid    <= w_rvalid_n;
            r_rdata     <= w_rdata_n;
            r_mem_en    <= w_mem_en_n;
            r_mem_we    <= w_mem_we_n;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_wdata <= w_mem_wdata_n;
`ifdef ARB_LOCK_EN
            r_locked    <= w_locked_n;
            r_lock_cnt  <= w_lock_cnt_n;
`endif
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rvalid    = r_rvalid;
    assign bus.rdata     = r_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level arbitration model plus memory model.
module tb_mem_arbiter;
    localparam int NC = 4, AW = 16, DW = 12, LAT = 2, MAXL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .MEM_LAT(LAT), .MAX_LOCK(MAXL)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [NC-1:0] t_req = '0, t_we = '0, t_lock = '0, t_hold = '0;
    logic [AW-1:0] t_addr [NC];
    logic [DW-1:0] t_wdata[NC];

    always_comb begin
        bus.req  = t_req;
        bus.we   = t_we;
        bus.lock = t_lock;
        for (int i = 0; i < NC; i++) begin
            bus.addr[i*AW +: AW]  = t_addr[i];
            bus.wdata[i*DW +: DW] = t_wdata[i];
        end
    end

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 'h40) ? DW'('hABC) : DW'(a * 37 + 5);
    endfunction

    // Memory with MEM_LAT-cycle read pipeline
    logic [DW-1:0] mem  [256];
    logic [DW-1:0] rpipe[LAT];
    bit            mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
        rpipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[7:0]] : DW'(0);
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.mem_rdata = rpipe[LAT-1];

    typedef struct {int cyc; int core; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} gexp_t;
    typedef struct {int cyc; int core; logic [DW-1:0] data;} rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];
    logic [DW-1:0] ref_mem[256];
    int  cyc = 0, free_at = 0, rr = 0;
    int  checks = 0, errors = 0;
    bit  model_en = 1'b1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: transactions serialized; port free again 2 cycles after a write
    // grant and MEM_LAT+2 after a read grant; winner by rotating priority.
    initial begin
        int n, w;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            n = cyc + 1;
            if (rst) begin
                rr = 0;
                free_at = n + 1;
                gq.delete();
                rq.delete();
            end else if (model_en && n >= free_at && t_req != '0) begin
                w = -1;
                for (int k = 0; k < NC; k++)
                    if (w < 0 && t_req[(rr + k) % NC]) w = (rr + k) % NC;
                gq.push_back('{cyc: n, core: w, we: t_we[w], addr: t_addr[w], wdata: t_wdata[w]});
                if (t_we[w]) begin
                    ref_mem[t_addr[w][7:0]] = t_wdata[w];
                    free_at = n + 2;
                end else begin
                    rq.push_back('{cyc: n + 1 + LAT, core: w, data: ref_mem[t_addr[w][7:0]]});
                    free_at = n + 2 + LAT;
                end
                rr = (w + 1) % NC;
            end
            cyc = n;
        end
    end

    // Monitor: pops expectations whenever gnt or rvalid is presented
    initial begin
        gexp_t ge;
        rexp_t re;
        forever begin
            @(negedge clk);
            if (model_en) begin
                chk("gnt_rvalid_overlap", int'(bus.gnt != '0 && bus.rvalid != '0), 0);
                if (gq.size() > 0 && gq[0].cyc < cyc) begin
                    ge = gq.pop_front();
                    chk("gnt_missing_core", -1, ge.core);
                end
                if (rq.size() > 0 && rq[0].cyc < cyc) begin
                    re = rq.pop_front();
                    chk("rvalid_missing_core", -1, re.core);
                end
                if (bus.gnt != '0) begin
                    if (gq.size() == 0) chk("gnt_unexpected", int'(bus.gnt), 0);
                    else begin
                        ge = gq.pop_front();
                        chk("gnt_cycle", cyc, ge.cyc);
                        chk("gnt_vec", int'(bus.gnt), int'(NC'(1) << ge.core));
                        chk("mem_en", int'(bus.mem_en), 1);
                        chk("mem_we", int'(bus.mem_we), int'(ge.we));
                        chk("mem_addr", int'(bus.mem_addr), int'(ge.addr));
                        chk("mem_wdata", int'(bus.mem_wdata), int'(ge.wdata));
                    end
                end else begin
                    chk("mem_en_idle", int'(bus.mem_en), 0);
                end
                if (bus.rvalid != '0) begin
                    if (rq.size() == 0) chk("rvalid_unexpected", int'(bus.rvalid), 0);
                    else begin
                        re = rq.pop_front();
                        chk("rvalid_cycle", cyc, re.cyc);
                        chk("rvalid_vec", int'(bus.rvalid), int'(NC'(1) << re.core));
                        chk("rdata", int'(bus.rdata), int'(re.data));
                    end
                end
            end
        end
    end

    task automatic new_req(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        t_req[c] = 1'b1; t_we[c] = w; t_addr[c] = a; t_wdata[c] = d;
    endtask

    task automatic rand_req(input int c);
        new_req(c, 1'($urandom), AW'(($urandom & 32'hFF00) | $urandom_range(0, 15)), DW'($urandom));
    endtask

    // One cycle of core behaviour: drop (or renew) a granted request, maybe raise new ones
    task automatic step(input bit rnd);
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            if (bus.gnt[i] && !t_hold[i]) begin
                if (rnd && $urandom_range(0, 1) == 1) rand_req(i);
                else t_req[i] = 1'b0;
            end
            if (rnd && !t_req[i] && $urandom_range(0, 3) == 0) rand_req(i);
`ifndef ARB_LOCK_EN
            if (rnd) t_lock[i] = 1'($urandom);
`endif
        end
    endtask

    task automatic wait_gnt(input int c, input int bound);
        int k;
        k = 0;
        while (!bus.gnt[c] && k < bound) begin
            step(1'b0);
            k++;
        end
        chk($sformatf("wait_gnt%0d", c), int'(bus.gnt[c]), 1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_gnt"},       int'(bus.gnt), 0);
        chk({tag, "_rvalid"},    int'(bus.rvalid), 0);
        chk({tag, "_rdata"},     int'(bus.rdata), 0);
        chk({tag, "_mem_en"},    int'(bus.mem_en), 0);
        chk({tag, "_mem_we"},    int'(bus.mem_we), 0);
        chk({tag, "_mem_addr"},  int'(bus.mem_addr), 0);
        chk({tag, "_mem_wdata"}, int'(bus.mem_wdata), 0);
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin
            t_addr[i] = '0;
            t_wdata[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;

        new_req(1, 1'b0, 16'h0040, 12'h000);
        wait_gnt(1, 10);
        repeat (6) step(1'b0);

        new_req(2, 1'b1, 16'h0010, 12'h123);
        wait_gnt(2, 10);
        repeat (4) step(1'b0);

        t_hold = '1;
        for (int i = 0; i < NC; i++) new_req(i, 1'b1, AW'(16'h0020 + i), DW'(i * 12'h111));
        repeat (16) step(1'b0);
        t_hold = '0;
        t_req = '0;
        repeat (4) step(1'b0);

        // Reset while a core0 read is waiting on memory
        new_req(0, 1'b0, 16'h0041, 12'h000);
        wait_gnt(0, 10);
        step(1'b0);
        rst = 1'b1;
        step(1'b0);
        chk_zero_outputs("reset_wait");
        rst = 1'b0;
        new_req(0, 1'b1, 16'h0042, 12'h5A5);
        new_req(3, 1'b1, 16'h0043, 12'h3C3);
        repeat (8) step(1'b0);

        t_hold[3] = 1'b1;
        new_req(3, 1'b1, 16'h0044, 12'h0F0);
        wait_gnt(3, 10);
        new_req(0, 1'b1, 16'h0045, 12'h00F);
        repeat (8) step(1'b0);
        t_hold = '0;
        t_req = '0;
        repeat (4) step(1'b0);

        repeat (1500) step(1'b1);
        t_req = '0;
        t_lock = '0;
        repeat (12) step(1'b0);
        chk("grants_drained", gq.size(), 0);
        chk("reads_drained", rq.size(), 0);

`ifdef ARB_LOCK_EN
        begin
            int seq[10];
            int ng, n2, exp;
            model_en = 1'b0;
            ng = 0;
            n2 = 0;
            t_hold[2] = 1'b1;
            t_lock[2] = 1'b1;
            new_req(2, 1'b1, 16'h0050, 12'h222);
            for (int k = 0; k < 200 && ng < 10; k++) begin
                step(1'b0);
                if (k == 0) new_req(1, 1'b1, 16'h0051, 12'h111);
                for (int i = 0; i < NC; i++)
                    if (bus.gnt[i]) begin
                        seq[ng] = i;
                        ng++;
                        if (i == 2) n2++;
                    end
                if (n2 == 10) begin
                    t_hold[2] = 1'b0;
                    t_req[2] = 1'b0;
                end
            end
            chk("lock_grants", ng, 10);
            for (int k = 0; k < ng; k++) begin
                exp = (k == 8) ? 1 : 2;
                chk($sformatf("lock_seq%0d", k), seq[k], exp);
            end
            t_hold = '0;
            t_lock = '0;
            t_req = '0;
            repeat (4) step(1'b0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
